// File: rtl/cpu_pipe_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pipe_pkg
// Shared constants for the CPU pipeline registers.
//   CPU_RESET_PC   : PC value held by pipeline registers after reset
//   NOP_INSTR      : encoding used for bubbles (all zeros)
//   EXC_NONE       : exception code meaning "no exception"
//   *_W_DEF        : default widths for the pipeline sideband fields
// ---------------------------------------------------------------------------
package cpu_pipe_pkg;

   localparam int          DATA_W_DEF   = 32;
   localparam int          DST_W_DEF    = 5;
   localparam int          TNEW_W_DEF   = 3;
   localparam int          EXC_W_DEF    = 5;

   localparam logic [31:0] CPU_RESET_PC = 32'h0000_3000;
   localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
   localparam logic [4:0]  EXC_NONE     = 5'd0;

endpackage

// File: rtl/pipe_field_reg.sv
// ---------------------------------------------------------------------------
// pipe_field_reg
// One field of a pipeline register with synchronous reset, load enable and
// synchronous clear-to-value.
//   clk     : rising-edge clock
//   reset   : synchronous active-high reset, loads RST_VAL
//   en      : capture enable (low = hold)
//   clr     : when enabled, load clr_val instead of d
//   d       : next value on a normal load
//   clr_val : value loaded when clr is set
//   q       : registered field value
// Priority on each edge: reset > hold (en=0) > clear > load.
// ---------------------------------------------------------------------------
module pipe_field_reg #(
   parameter int           W       = 1,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic         clr,
   input  logic [W-1:0] d,
   input  logic [W-1:0] clr_val,
   output logic [W-1:0] q
);

   logic [W-1:0] q_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         q_reg <= RST_VAL;
      end else if (en) begin
         q_reg <= clr ? clr_val : d;
      end
   end

   assign q = q_reg;

endmodule

// File: rtl/em_stage_reg.sv
// ---------------------------------------------------------------------------
// em_stage_reg
// EX/MEM pipeline register. Carries the execute-stage result bundle into the
// memory stage with stall (hold), flush (bubble) and a valid bit.
//   clk, reset                         : clock, synchronous active-high reset
//   stall_i                            : hold every output this edge
//   flush_i                            : capture a bubble instead of the entry
//   valid_i                            : incoming entry is a real instruction
//   instr_i/pc_i/alurs_i/wd_i          : E-stage payload (DATA_W each)
//   dst_i, tnew_i, exc_i, bd_i         : dest reg, Tnew, exception, delay slot
//   *_o                                : registered copies, valid_o
// A bubble (flush or dead entry) zeroes everything that could create a
// hazard or exception, but still records pc/bd so EPC can be computed.
// ---------------------------------------------------------------------------
module em_stage_reg
   import cpu_pipe_pkg::*;
#(
   parameter int                DATA_W   = DATA_W_DEF,
   parameter int                DST_W    = DST_W_DEF,
   parameter int                TNEW_W   = TNEW_W_DEF,
   parameter int                EXC_W    = EXC_W_DEF,
   parameter logic [DATA_W-1:0] RESET_PC = DATA_W'(CPU_RESET_PC)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall_i,
   input  logic              flush_i,
   input  logic              valid_i,
   input  logic [DATA_W-1:0] instr_i,
   input  logic [DATA_W-1:0] pc_i,
   input  logic [DATA_W-1:0] alurs_i,
   input  logic [DATA_W-1:0] wd_i,
   input  logic [DST_W-1:0]  dst_i,
   input  logic [TNEW_W-1:0] tnew_i,
   input  logic [EXC_W-1:0]  exc_i,
   input  logic              bd_i,
   output logic [DATA_W-1:0] instr_o,
   output logic [DATA_W-1:0] pc_o,
   output logic [DATA_W-1:0] alurs_o,
   output logic [DATA_W-1:0] wd_o,
   output logic [DST_W-1:0]  dst_o,
   output logic [TNEW_W-1:0] tnew_o,
   output logic [EXC_W-1:0]  exc_o,
   output logic              bd_o,
   output logic              valid_o
);

   localparam int NPAY = 3;   // instr, alurs, wd share the bubble behaviour

   logic              load_en;
   logic              kill;
   logic [TNEW_W-1:0] tnew_next;
   logic [DATA_W-1:0] pay_d [NPAY];
   logic [DATA_W-1:0] pay_q [NPAY];

   // Stall gates every field, which is also what makes stall beat flush.
   assign load_en = ~stall_i;
   // A flushed entry and a dead (invalid) entry are captured identically.
   assign kill    = flush_i | ~valid_i;

   // Tnew counts down by one per stage but saturates at zero.
   assign tnew_next = (tnew_i == '0) ? '0 : tnew_i - TNEW_W'(1);

   always_comb begin
      pay_d[0] = instr_i;
      pay_d[1] = alurs_i;
      pay_d[2] = wd_i;
   end

   // Wide payload fields: bubble value is NOP for instr, zero for the rest.
   generate
      for (genvar gi = 0; gi < NPAY; gi++) begin : g_pay
         localparam logic [DATA_W-1:0] BUBBLE_VAL =
            (gi == 0) ? DATA_W'(NOP_INSTR) : '0;

         pipe_field_reg #(.W(DATA_W), .RST_VAL(BUBBLE_VAL)) u_pay (
            .clk     (clk),
            .reset   (reset),
            .en      (load_en),
            .clr     (kill),
            .d       (pay_d[gi]),
            .clr_val (BUBBLE_VAL),
            .q       (pay_q[gi])
         );
      end
   endgenerate

   assign instr_o = pay_q[0];
   assign alurs_o = pay_q[1];
   assign wd_o    = pay_q[2];

   // pc and bd are always captured, even for bubbles, for EPC computation.
   pipe_field_reg #(.W(DATA_W), .RST_VAL(RESET_PC)) u_pc (
      .clk     (clk),
      .reset   (reset),
      .en      (load_en),
      .clr     (1'b0),
      .d       (pc_i),
      .clr_val ('0),
      .q       (pc_o)
   );

   pipe_field_reg #(.W(1), .RST_VAL(1'b0)) u_bd (
      .clk     (clk),
      .reset   (reset),
      .en      (load_en),
      .clr     (1'b0),
      .d       (bd_i),
      .clr_val (1'b0),
      .q       (bd_o)
   );

   pipe_field_reg #(.W(DST_W), .RST_VAL('0)) u_dst (
      .clk     (clk),
      .reset   (reset),
      .en      (load_en),
      .clr     (kill),
      .d       (dst_i),
      .clr_val ('0),
      .q       (dst_o)
   );

   pipe_field_reg #(.W(TNEW_W), .RST_VAL('0)) u_tnew (
      .clk     (clk),
      .reset   (reset),
      .en      (load_en),
      .clr     (kill),
      .d       (tnew_next),
      .clr_val ('0),
      .q       (tnew_o)
   );

   pipe_field_reg #(.W(EXC_W), .RST_VAL(EXC_W'(EXC_NONE))) u_exc (
      .clk     (clk),
      .reset   (reset),
      .en      (load_en),
      .clr     (kill),
      .d       (exc_i),
      .clr_val (EXC_W'(EXC_NONE)),
      .q       (exc_o)
   );

   // With clr=kill the captured valid is valid_i & ~flush_i.
   pipe_field_reg #(.W(1), .RST_VAL(1'b0)) u_valid (
      .clk     (clk),
      .reset   (reset),
      .en      (load_en),
      .clr     (kill),
      .d       (1'b1),
      .clr_val (1'b0),
      .q       (valid_o)
   );

endmodule
